// File: rtl/uart_rx_frame_ctrl.sv
// Byte-level frame parser behind the UART receiver: hunts for SOF, collects a
// length-prefixed checksummed payload, holds a verified frame until acked.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SOF           = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 320
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_tick,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_done_tick,
  input  logic                       frame_ack,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 frame_len,
  output logic                       frame_valid,
  output logic                       err_chk,
  output logic                       err_len,
  output logic                       err_timeout,
  output logic                       rx_overrun
);

  localparam int             AW        = $clog2(MAX_LEN);
  localparam int             TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {HUNT, LEN_S, PAYLOAD, CHK_S, HOLD} state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          fv_q, fv_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_to_q, err_to_d;
  logic          ovr_q, ovr_d;
  logic          wr_en_s;
  logic          tick_exp_s;
  logic [TW-1:0] to_next_s;
  logic [7:0]    pbuf_q [MAX_LEN];

  // Next-state, checksum accumulation and inter-byte timeout supervision
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    to_d      = to_q;
    fv_d      = fv_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_to_d  = 1'b0;
    ovr_d     = 1'b0;
    wr_en_s   = 1'b0;
    // A byte in the same cycle always pre-empts an expiring tick
    tick_exp_s = s_tick && (to_q >= TO_LAST);
    to_next_s  = (s_tick && (to_q < TO_LAST)) ? to_q + TW'(1) : to_q;
    case (state_q)
      HUNT: begin
        to_d = '0;
        fv_d = 1'b0;
        if (rx_done_tick && (rx_data == SOF)) state_d = LEN_S;
        else                                  state_d = HUNT;
      end
      LEN_S: begin
        if (rx_done_tick) begin
          to_d = '0;
          if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
            err_len_d = 1'b1;
            state_d   = HUNT;
          end else begin
            len_d   = rx_data;
            sum_d   = rx_data;
            idx_d   = 8'd0;
            state_d = PAYLOAD;
          end
        end else if (tick_exp_s) begin
          err_to_d = 1'b1;
          state_d  = HUNT;
        end else begin
          to_d = to_next_s;
        end
      end
      PAYLOAD: begin
        if (rx_done_tick) begin
          to_d    = '0;
          wr_en_s = 1'b1;
          sum_d   = csum_add(sum_q, rx_data);
          idx_d   = idx_q + 8'd1;
          if ((idx_q + 8'd1) == len_q) state_d = CHK_S;
          else                         state_d = PAYLOAD;
        end else if (tick_exp_s) begin
          err_to_d = 1'b1;
          state_d  = HUNT;
        end else begin
          to_d = to_next_s;
        end
      end
      CHK_S: begin
        if (rx_done_tick) begin
          to_d = '0;
          if (csum_add(sum_q, rx_data) == 8'd0) begin
            fv_d    = 1'b1;
            state_d = HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = HUNT;
          end
        end else if (tick_exp_s) begin
          err_to_d = 1'b1;
          state_d  = HUNT;
        end else begin
          to_d = to_next_s;
        end
      end
      HOLD: begin
        to_d  = '0;
        ovr_d = rx_done_tick;
        if (frame_ack) begin
          fv_d    = 1'b0;
          state_d = HUNT;
        end else begin
          fv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      default: begin
        fv_d    = 1'b0;
        to_d    = '0;
        state_d = HUNT;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      len_q     <= 8'd0;
      sum_q     <= 8'd0;
      idx_q     <= 8'd0;
      to_q      <= '0;
      fv_q      <= 1'b0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      to_q      <= to_d;
      fv_q      <= fv_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      ovr_q     <= ovr_d;
    end
  end

  // Payload buffer; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) pbuf_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign rd_data     = pbuf_q[rd_addr];
  assign frame_len   = len_q;
  assign frame_valid = fv_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_to_q;
  assign rx_overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: frame-level stimulus pushes expected
// events with their cycle, an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_uart_rx_frame_ctrl;

  localparam logic [7:0] SOF = 8'hA5;
  localparam int K_CHK = 0, K_LEN = 1, K_TO = 2, K_OVR = 3, K_VAL = 4, K_REL = 5, K_NONE = 7;

  typedef struct packed {
    logic [2:0]   kind;
    logic [31:0]  cyc;
    logic [7:0]   len;
    logic [127:0] pl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n, s_tick, rx_done_tick, frame_ack;
  logic [7:0] rx_data;
  logic [3:0] rd_addr;
  logic [7:0] rd_data, frame_len;
  logic       frame_valid, err_chk, err_len, err_timeout, rx_overrun;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  bit          tick_en = 1'b1;

  uart_rx_frame_ctrl #(.SOF(8'hA5), .MAX_LEN(16), .TIMEOUT_TICKS(320)) dut (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .frame_ack(frame_ack), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_len(frame_len), .frame_valid(frame_valid),
    .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input logic [31:0] c, input int len, input logic [127:0] pl);
    exp_t e;
    e.kind = 3'(k); e.cyc = c; e.len = 8'(len); e.pl = pl;
    exp_q.push_back(e);
  endtask

  function automatic logic rnd_tick();
    return tick_en && ($urandom_range(0, 1) == 1);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One byte strobe; tk<0 means random s_tick in the same cycle
  task automatic send(input logic [7:0] b, input int tk, input int k, input int len, input logic [127:0] pl);
    rx_data = b; rx_done_tick = 1'b1;
    s_tick = (tk < 0) ? rnd_tick() : (tk != 0);
    if (k != K_NONE) push(k, cyc + 1, len, pl);
    step();
    rx_done_tick = 1'b0; s_tick = 1'b0;
    repeat ($urandom_range(0, 2)) begin s_tick = rnd_tick(); step(); end
    s_tick = 1'b0;
  endtask

  task automatic release_frame(input int n_ovr, input bit ackb, input int len, input logic [127:0] pl);
    repeat (n_ovr) send(8'h5A, -1, K_OVR, len, pl);
    frame_ack = 1'b1;
    if (ackb) begin
      rx_done_tick = 1'b1; rx_data = 8'h5A;
      push(K_OVR, cyc + 1, len, pl);
    end
    push(K_REL, cyc + 1, len, pl);
    step();
    frame_ack = 1'b0; rx_done_tick = 1'b0;
  endtask

  // Frame outcome derived from the checksum rule on the whole frame
  task automatic frame(input int len, input logic [127:0] pl, input logic [7:0] c, input int n_ovr, input bit ackb);
    int s;
    bit good;
    s = len;
    for (int i = 0; i < len; i++) s += int'(pl[i*8 +: 8]);
    good = ((s + int'(c)) % 256) == 0;
    send(SOF, -1, K_NONE, 0, '0);
    send(8'(len), -1, K_NONE, 0, '0);
    for (int i = 0; i < len; i++) send(pl[i*8 +: 8], -1, K_NONE, 0, '0);
    send(c, -1, good ? K_VAL : K_CHK, len, pl);
    if (good) release_frame(n_ovr, ackb, len, pl);
  endtask

  task automatic rand_frame(input bit corrupt);
    int len, s;
    logic [127:0] pl;
    logic [7:0] c;
    len = $urandom_range(1, 16);
    pl = '0; s = len;
    for (int i = 0; i < len; i++) begin
      pl[i*8 +: 8] = 8'($urandom);
      s += int'(pl[i*8 +: 8]);
    end
    c = 8'((256 - (s % 256)) % 256);
    if (corrupt) c = c + 8'($urandom_range(1, 255));
    frame(len, pl, c, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
  endtask

  task automatic bad_len(input logic [7:0] b);
    send(SOF, -1, K_NONE, 0, '0);
    send(b, -1, K_LEN, 0, '0);
  endtask

  task automatic timeout_test(input bit variant);
    logic [127:0] pl;
    pl = '0; pl[7:0] = 8'h11; pl[15:8] = 8'h22;
    tick_en = 1'b0;
    send(SOF, 0, K_NONE, 0, '0);
    send(8'h02, 0, K_NONE, 0, '0);
    send(8'h11, 0, K_NONE, 0, '0);
    for (int i = 0; i < 319; i++) begin
      s_tick = 1'b1; step(); s_tick = 1'b0;
      if ($urandom_range(0, 3) == 0) step();
    end
    if (!variant) begin
      s_tick = 1'b1;
      push(K_TO, cyc + 1, 0, '0);
      step();
      s_tick = 1'b0;
    end else begin
      send(8'h22, 1, K_NONE, 0, '0);
      for (int i = 0; i < 319; i++) begin s_tick = 1'b1; step(); end
      send(8'hCB, 1, K_VAL, 2, pl);
      release_frame(0, 1'b0, 2, pl);
    end
    tick_en = 1'b1;
  endtask

  task automatic observe(input int k);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", k, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      chk("event_cycle", cyc, e.cyc);
      if ((k == int'(e.kind)) && (k == K_VAL || k == K_REL)) begin
        chk("frame_len", 32'(frame_len), 32'(e.len));
        for (int i = 0; i < int'(e.len); i++) begin
          rd_addr = 4'(i);
          #0.1;
          chk("payload", 32'(rd_data), 32'(e.pl[i*8 +: 8]));
        end
      end
    end
  endtask

  // Monitor: every output pulse or frame_valid edge is one observed event
  initial begin
    logic fv_prev;
    fv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        fv_prev = 1'b0;
      end else begin
        if (err_chk)     observe(K_CHK);
        if (err_len)     observe(K_LEN);
        if (err_timeout) observe(K_TO);
        if (rx_overrun)  observe(K_OVR);
        if (frame_valid && !fv_prev) observe(K_VAL);
        if (!frame_valid && fv_prev) observe(K_REL);
        fv_prev = frame_valid;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_frame_len", 32'(frame_len), 32'd0);
    chk("rst_err_chk", 32'(err_chk), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pl;
    reset_n = 1'b0; s_tick = 1'b0; rx_done_tick = 1'b0; frame_ack = 1'b0;
    rx_data = 8'h00; rd_addr = 4'd0;
    step(); step();
    check_reset_outputs();
    reset_n = 1'b1;
    step();

    pl = '0; pl[23:0] = 24'h332211;
    frame(3, pl, 8'h97, 0, 1'b0);
    send(8'h00, -1, K_NONE, 0, '0);
    send(8'hFF, -1, K_NONE, 0, '0);
    pl = '0; pl[7:0] = 8'h7E;
    frame(1, pl, 8'h81, 0, 1'b0);
    pl = '0; pl[23:0] = 24'h332211;
    frame(3, pl, 8'h98, 0, 1'b0);
    bad_len(8'h00);
    bad_len(8'h11);
    timeout_test(1'b0);
    pl = '0; pl[7:0] = 8'h05;
    frame(1, pl, 8'hFA, 0, 1'b0);
    timeout_test(1'b1);
    pl = '0; pl[23:0] = 24'hC0FFEE;
    frame(3, pl, 8'(256 - ((3 + 8'hEE + 8'hFF + 8'hC0) % 256)), 1, 1'b1);

    send(SOF, -1, K_NONE, 0, '0);
    send(8'h02, -1, K_NONE, 0, '0);
    send(8'h11, -1, K_NONE, 0, '0);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    step(); step();
    reset_n = 1'b1;
    step();
    pl = '0; pl[7:0] = 8'h05;
    frame(1, pl, 8'hFA, 0, 1'b0);

    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: rand_frame(1'b0);
        5, 6:          rand_frame(1'b1);
        7:             bad_len(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
        default: begin
          repeat ($urandom_range(1, 3)) begin
            logic [7:0] g;
            g = 8'($urandom);
            if (g == SOF) g = 8'h00;
            send(g, -1, K_NONE, 0, '0);
          end
        end
      endcase
    end

    repeat (10) step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
